// File: rtl/multi_cycle_seq.sv
// multi_cycle_seq: sequences the stack cycles of CALL, RET, RTI and INT.
// After decode issues a start, this block emits one push or pop per cycle
// (mem_op / word_sel), counting down on step, and stalls the front end via busy.
// Optional feature macro: MCS_INT_EN. When defined, op=11 (INT) is a legal
// instruction sequenced over INT_STEPS cycles. When undefined, a start with
// op=11 is rejected with a one-cycle err pulse.
// Handshake: start is a single-cycle request sampled only in IDLE; there is no
// ready signal. busy=1 means any start this cycle is ignored without error.
// done/err are one-cycle pulses in the cycle after completion/rejection.
// The FSM state is exposed through busy, which is 1 exactly when the
// state register is ACTIVE.
module multi_cycle_seq #(
  parameter int CNT_W      = 3,
  parameter int CALL_STEPS = 2,
  parameter int RET_STEPS  = 2,
  parameter int RTI_STEPS  = 3,
  parameter int INT_STEPS  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             hold,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] step,
  output logic [1:0]       mem_op,
  output logic [1:0]       word_sel,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_RTI  = 2'b10;
  localparam logic [1:0] OP_INT  = 2'b11;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_PUSH = 2'b01;
  localparam logic [1:0] MEM_POP  = 2'b10;

  localparam logic [1:0] W_PCL = 2'b00;
  localparam logic [1:0] W_PCH = 2'b01;
  localparam logic [1:0] W_FLG = 2'b10;

`ifdef MCS_INT_EN
  localparam bit INT_LEGAL = 1'b1;
`else
  localparam bit INT_LEGAL = 1'b0;
`endif

  // Parameter sanity: a step count must fit in the counter.
  if (CNT_W < 2 || CNT_W > 8) begin : g_bad_cnt_w
    $error("multi_cycle_seq: CNT_W=%0d outside 2..8", CNT_W);
  end
  if (CALL_STEPS < 0 || CALL_STEPS >= (1 << CNT_W)) begin : g_bad_call
    $error("multi_cycle_seq: CALL_STEPS=%0d does not fit CNT_W=%0d", CALL_STEPS, CNT_W);
  end
  if (RET_STEPS < 0 || RET_STEPS >= (1 << CNT_W)) begin : g_bad_ret
    $error("multi_cycle_seq: RET_STEPS=%0d does not fit CNT_W=%0d", RET_STEPS, CNT_W);
  end
  if (RTI_STEPS < 0 || RTI_STEPS >= (1 << CNT_W)) begin : g_bad_rti
    $error("multi_cycle_seq: RTI_STEPS=%0d does not fit CNT_W=%0d", RTI_STEPS, CNT_W);
  end
  if (INT_STEPS < 0 || INT_STEPS >= (1 << CNT_W)) begin : g_bad_int
    $error("multi_cycle_seq: INT_STEPS=%0d does not fit CNT_W=%0d", INT_STEPS, CNT_W);
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] start_steps;
  logic [CNT_W-1:0] step_dec;
  logic             op_legal;

  // Number of stack cycles for a given instruction kind.
  function automatic logic [CNT_W-1:0] steps_of(input logic [1:0] o);
    logic [CNT_W-1:0] n;
    case (o)
      OP_CALL: n = CNT_W'(CALL_STEPS);
      OP_RET:  n = CNT_W'(RET_STEPS);
      OP_RTI:  n = CNT_W'(RTI_STEPS);
      default: n = CNT_W'(INT_STEPS);
    endcase
    return n;
  endfunction

  // Stack action {mem_op, word_sel} for an op at a given remaining-step value.
  // Steps above an op's listed range are idle stack cycles.
  function automatic logic [3:0] action_of(input logic [1:0] o,
                                           input logic [CNT_W-1:0] s);
    logic [3:0] a;
    a = {MEM_NONE, W_PCL};
    case (o)
      OP_CALL: begin
        if (s == CNT_W'(2))      a = {MEM_PUSH, W_PCH};
        else if (s == CNT_W'(1)) a = {MEM_PUSH, W_PCL};
      end
      OP_RET: begin
        if (s == CNT_W'(2))      a = {MEM_POP, W_PCL};
        else if (s == CNT_W'(1)) a = {MEM_POP, W_PCH};
      end
      OP_INT: begin
        if (s == CNT_W'(3))      a = {MEM_PUSH, W_FLG};
        else if (s == CNT_W'(2)) a = {MEM_PUSH, W_PCH};
        else if (s == CNT_W'(1)) a = {MEM_PUSH, W_PCL};
      end
      default: begin
        if (s == CNT_W'(3))      a = {MEM_POP, W_PCL};
        else if (s == CNT_W'(2)) a = {MEM_POP, W_PCH};
        else if (s == CNT_W'(1)) a = {MEM_POP, W_FLG};
      end
    endcase
    return a;
  endfunction

  assign start_steps = steps_of(op);
  assign step_dec    = step - CNT_W'(1);
  assign op_legal    = (op != OP_INT) || INT_LEGAL;

  // Sequencer FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_CALL;
      busy     <= 1'b0;
      step     <= '0;
      mem_op   <= MEM_NONE;
      word_sel <= W_PCL;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (flush) begin
        // Abort wins over start, hold and completion; no done pulse.
        state    <= IDLE;
        busy     <= 1'b0;
        step     <= '0;
        mem_op   <= MEM_NONE;
        word_sel <= W_PCL;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (!op_legal) begin
                err <= 1'b1;
              end else if (start_steps == '0) begin
                // Nothing to push or pop: complete without ever going busy.
                done <= 1'b1;
              end else begin
                state                <= ACTIVE;
                busy                 <= 1'b1;
                op_q                 <= op;
                step                 <= start_steps;
                {mem_op, word_sel}   <= action_of(op, start_steps);
              end
            end
          end
          default: begin
            // ACTIVE: start is ignored; hold freezes everything.
            if (!hold) begin
              if (step <= CNT_W'(1)) begin
                // Last stack cycle (step never reaches 0 while ACTIVE, the
                // <= only keeps the counter from ever wrapping).
                state    <= IDLE;
                busy     <= 1'b0;
                step     <= '0;
                mem_op   <= MEM_NONE;
                word_sel <= W_PCL;
                done     <= 1'b1;
              end else begin
                step               <= step_dec;
                {mem_op, word_sel} <= action_of(op_q, step_dec);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Directed testbench for multi_cycle_seq with default parameters.
// Each scenario task loads a per-cycle stimulus table and a table of expected
// outputs, then walks them one cycle at a time: inputs are applied 1ns after
// a rising edge and the outputs of that same cycle are compared immediately.
// Expected word: {busy, step[2:0], mem_op, word_sel, done, err}.
// Stimulus word: {rst_n, start, op[1:0], hold, flush}.
module tb_multi_cycle_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic       hold;
  logic       flush;
  logic       busy;
  logic [2:0] step;
  logic [1:0] mem_op;
  logic [1:0] word_sel;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [5:0] stim_q[$];
  logic [9:0] exp_q[$];

  localparam logic [1:0] NONE = 2'b00, PUSH = 2'b01, POP = 2'b10;
  localparam logic [1:0] PCL = 2'b00, PCH = 2'b01, FLG = 2'b10;
  localparam logic [1:0] CALL = 2'b00, RET = 2'b01, RTI = 2'b10, INT = 2'b11;

  localparam logic [5:0] IDL   = 6'b10_00_00;  // out of reset, nothing requested
  localparam logic [9:0] Z     = 10'b0;        // all outputs zero
  localparam logic [9:0] DN    = 10'b0000_0000_10;
  localparam logic [9:0] ER    = 10'b0000_0000_01;

  multi_cycle_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .hold     (hold),
    .flush    (flush),
    .busy     (busy),
    .step     (step),
    .mem_op   (mem_op),
    .word_sel (word_sel),
    .done     (done),
    .err      (err)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] si(bit r, bit s, logic [1:0] o, bit h, bit f);
    return {r, s, o, h, f};
  endfunction

  function automatic logic [9:0] ev(bit b, logic [2:0] s, logic [1:0] m,
                                    logic [1:0] w);
    return {b, s, m, w, 2'b00};
  endfunction

  task automatic test_reset();
    // Reset held with start/hold high, then a start in the first released cycle.
    stim_q = '{si(0,1,CALL,1,0), si(1,1,CALL,0,0), IDL, IDL, IDL, IDL};
    exp_q  = '{Z, Z, ev(1,3'd2,PUSH,PCH), ev(1,3'd1,PUSH,PCL), DN, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL reset c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call();
    // hold=1 in IDLE must not block acceptance.
    stim_q = '{si(1,1,CALL,1,0), IDL, IDL, IDL, IDL};
    exp_q  = '{Z, ev(1,3'd2,PUSH,PCH), ev(1,3'd1,PUSH,PCL), DN, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL call c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ret();
    stim_q = '{si(1,1,RET,0,0), IDL, IDL, IDL, IDL};
    exp_q  = '{Z, ev(1,3'd2,POP,PCL), ev(1,3'd1,POP,PCH), DN, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL ret c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rti_hold();
    // hold=1 in cycles 2-3 keeps step=2 / PC high for three cycles.
    stim_q = '{si(1,1,RTI,0,0), IDL, si(1,0,RET,1,0), si(1,0,RET,1,0),
               IDL, IDL, IDL, IDL};
    exp_q  = '{Z, ev(1,3'd3,POP,PCL), ev(1,3'd2,POP,PCH), ev(1,3'd2,POP,PCH),
               ev(1,3'd2,POP,PCH), ev(1,3'd1,POP,FLG), DN, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL rti_hold c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    // Flush mid-CALL, flush beating a start, and flush beating completion
    // while hold is also high: no done pulse anywhere.
    stim_q = '{si(1,1,CALL,0,0), si(1,0,CALL,0,1), si(1,1,CALL,0,1), IDL,
               si(1,1,RET,0,0), IDL, si(1,0,RET,1,1), IDL, IDL};
    exp_q  = '{Z, ev(1,3'd2,PUSH,PCH), Z, Z,
               Z, ev(1,3'd2,POP,PCL), ev(1,3'd1,POP,PCH), Z, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL flush c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    // start held high with RET: sequences begin in cycles 0, 3 and 6.
    stim_q = '{si(1,1,RET,0,0), si(1,1,RET,0,0), si(1,1,RET,0,0),
               si(1,1,RET,0,0), si(1,1,RET,0,0), si(1,1,RET,0,0),
               si(1,1,RET,0,0), si(1,1,RET,0,0), si(1,1,RET,0,0),
               IDL, IDL};
    exp_q  = '{Z, ev(1,3'd2,POP,PCL), ev(1,3'd1,POP,PCH), DN,
               ev(1,3'd2,POP,PCL), ev(1,3'd1,POP,PCH), DN,
               ev(1,3'd2,POP,PCL), ev(1,3'd1,POP,PCH), DN, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_int();
`ifdef MCS_INT_EN
    stim_q = '{si(1,1,INT,0,0), IDL, IDL, IDL, IDL, IDL};
    exp_q  = '{Z, ev(1,3'd3,PUSH,FLG), ev(1,3'd2,PUSH,PCH),
               ev(1,3'd1,PUSH,PCL), DN, Z};
`else
    // Rejected INT, then an INT request while ACTIVE is silently ignored.
    stim_q = '{si(1,1,INT,0,0), IDL, si(1,1,CALL,0,0), si(1,1,INT,0,0),
               IDL, IDL, IDL};
    exp_q  = '{Z, ER, Z, ev(1,3'd2,PUSH,PCH), ev(1,3'd1,PUSH,PCL), DN, Z};
`endif
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL int c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    // Reset (with hold high) at RTI step 2, then a RET right after release.
    stim_q = '{si(1,1,RTI,0,0), IDL, si(0,0,RTI,1,0), si(1,1,RET,0,0),
               IDL, IDL, IDL, IDL};
    exp_q  = '{Z, ev(1,3'd3,POP,PCL), ev(1,3'd2,POP,PCH), Z,
               ev(1,3'd2,POP,PCL), ev(1,3'd1,POP,PCH), DN, Z};
    foreach (stim_q[c]) begin
      {rst_n, start, op, hold, flush} = stim_q[c];
      checks++;
      if ({busy, step, mem_op, word_sel, done, err} !== exp_q[c]) begin
        errors++;
        $display("FAIL reset_mid c%0d: got %b required %b", c,
                 {busy, step, mem_op, word_sel, done, err}, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset, then the scenarios in sequence, then the report.
  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    op    = CALL;
    hold  = 1'b1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_call();
    test_ret();
    test_rti_hold();
    test_flush();
    test_back_to_back();
    test_int();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
